if_fetch_unit: RTL and testbench

IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

---
 rtl/if_fetch_unit.sv | 139 +++++++++++++
 tb/tb_if_fetch_unit.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction fetch stage with a single outstanding memory request
// and a one-entry instruction buffer feeding the IF/ID register.
//
// Ports:
//   clk, rst               clock; synchronous active-high reset
//   PCWrite                IF/ID accepts the presented instruction (0 = stall)
//   redirect, redirect_pc  taken branch/jump and its target
//   imem_req, imem_addr    instruction memory request and word address
//   imem_ack, imem_rdata   memory response strobe and data (same cycle)
//   IF_PC, IF_ins          presented instruction and its PC (zero when not valid)
//   IF_valid               IF_PC/IF_ins hold a real instruction
//   fetch_count            instructions accepted downstream (wraps)
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PCWrite,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] IF_PC,
    output logic [31:0] IF_ins,
    output logic        IF_valid,
    output logic [31:0] fetch_count
);

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HAVE  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [XLEN-1:0]   pc, pc_nxt;
    logic [XLEN-1:0]   req_addr, req_addr_nxt;
    logic [XLEN-1:0]   buf_pc, buf_pc_nxt;
    logic [XLEN-1:0]   buf_ins, buf_ins_nxt;
    logic [XLEN-1:0]   count, count_nxt;
    logic [XLEN-1:0]   target_c;
    logic [XLEN-1:0]   pc_inc_c;

    // Redirect targets are forced word-aligned; sequential PC wraps naturally.
    assign target_c = {redirect_pc[XLEN-1:2], 2'b00};
    assign pc_inc_c = pc + XLEN'(PC_STEP);

    // State and datapath registers; request/valid flags track the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FETCH;
            pc       <= RESET_PC;
            req_addr <= RESET_PC;
            buf_pc   <= '0;
            buf_ins  <= '0;
            count    <= '0;
            imem_req <= 1'b1;
            IF_valid <= 1'b0;
        end else begin
            state    <= state_nxt;
            pc       <= pc_nxt;
            req_addr <= req_addr_nxt;
            buf_pc   <= buf_pc_nxt;
            buf_ins  <= buf_ins_nxt;
            count    <= count_nxt;
            imem_req <= (state_nxt != HAVE);
            IF_valid <= (state_nxt == HAVE);
        end
    end

    // Next-state and datapath update. The buffer is cleared whenever HAVE is
    // left so IF_PC/IF_ins present a bubble outside HAVE.
    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        req_addr_nxt = req_addr;
        buf_pc_nxt   = buf_pc;
        buf_ins_nxt  = buf_ins;
        count_nxt    = count;

        case (state)
            FETCH: begin
                if (redirect) begin
                    pc_nxt = target_c;
                    if (imem_ack) begin
                        req_addr_nxt = target_c;
                    end else begin
                        // Request stays on the bus until acked, then is dropped.
                        state_nxt = DRAIN;
                    end
                end else if (imem_ack) begin
                    buf_pc_nxt  = req_addr;
                    buf_ins_nxt = imem_rdata;
                    state_nxt   = HAVE;
                end
            end
            DRAIN: begin
                if (redirect) begin
                    pc_nxt = target_c;
                end
                if (imem_ack) begin
                    // Newest target wins even if it arrives with the ack.
                    req_addr_nxt = redirect ? target_c : pc;
                    state_nxt    = FETCH;
                end
            end
            HAVE: begin
                if (redirect) begin
                    pc_nxt       = target_c;
                    req_addr_nxt = target_c;
                    buf_pc_nxt   = '0;
                    buf_ins_nxt  = '0;
                    state_nxt    = FETCH;
                end else if (PCWrite) begin
                    count_nxt    = count + XLEN'(1);
                    pc_nxt       = pc_inc_c;
                    req_addr_nxt = pc_inc_c;
                    buf_pc_nxt   = '0;
                    buf_ins_nxt  = '0;
                    state_nxt    = FETCH;
                end
            end
            default: begin
                state_nxt = FETCH;
            end
        endcase
    end

    assign imem_addr   = req_addr;
    assign IF_PC       = buf_pc;
    assign IF_ins      = buf_ins;
    assign fetch_count = count;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: a small memory model answers requests, and
// expected {PC, instruction} pairs are queued when an ack is given and popped
// when the fetch unit presents the instruction.
module tb_if_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;

    logic        clk;
    logic        rst;
    logic        PCWrite;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] IF_PC;
    logic [31:0] IF_ins;
    logic        IF_valid;
    logic [31:0] fetch_count;

    if_fetch_unit #(.RESET_PC(RESET_PC), .PC_STEP(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .PCWrite     (PCWrite),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .IF_PC       (IF_PC),
        .IF_ins      (IF_ins),
        .IF_valid    (IF_valid),
        .fetch_count (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned errors = 0;
    int unsigned checks = 0;
    logic [63:0] sb[$];
    logic [31:0] exp_addr;
    logic [31:0] exp_count;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'h5A5A_A5A5;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge; outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        exp_addr  = RESET_PC;
        exp_count = 32'h0;
        sb.delete();
    endtask

    // Acknowledge the current request in its first cycle and queue the result.
    task automatic ack_now(input string tag);
        chk({tag, "_req"}, 32'(imem_req), 32'h1);
        chk({tag, "_addr"}, imem_addr, exp_addr);
        sb.push_back({exp_addr, mem(exp_addr)});
        imem_ack   = 1'b1;
        imem_rdata = mem(imem_addr);
        tick();
        imem_ack   = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
    endtask

    // Compare the presented instruction against the scoreboard head.
    task automatic check_have(input string tag);
        logic [63:0] e;
        chk({tag, "_valid"}, 32'(IF_valid), 32'h1);
        chk({tag, "_req0"}, 32'(imem_req), 32'h0);
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s_sb: observed=empty expected=entry", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, "_pc"}, IF_PC, e[63:32]);
            chk({tag, "_ins"}, IF_ins, e[31:0]);
        end
    endtask

    task automatic accept(input string tag);
        check_have(tag);
        PCWrite = 1'b1;
        tick();
        PCWrite = 1'b0;
        exp_count = exp_count + 32'h1;
        exp_addr  = exp_addr + 32'h4;
        chk({tag, "_cnt"}, fetch_count, exp_count);
        chk({tag, "_next"}, imem_addr, exp_addr);
        chk({tag, "_bubble"}, IF_PC, 32'h0);
    endtask

    initial begin
        rst = 1'b1; PCWrite = 1'b0; redirect = 1'b0; redirect_pc = '0;
        imem_ack = 1'b0; imem_rdata = '0;

        // Reset state
        do_reset();
        chk("rst_req", 32'(imem_req), 32'h1);
        chk("rst_addr", imem_addr, RESET_PC);
        chk("rst_valid", 32'(IF_valid), 32'h0);
        chk("rst_cnt", fetch_count, 32'h0);
        chk("rst_ifpc", IF_PC, 32'h0);

        // Back-to-back stream at 3000, 3004, 3008
        for (int i = 0; i < 3; i++) begin
            ack_now("seq");
            accept("seq");
        end
        chk("seq_cnt3", fetch_count, 32'd3);

        // Stall in HAVE at 3004; acks while buffered must be ignored
        do_reset();
        ack_now("st0");
        accept("st0");
        ack_now("st1");
        for (int i = 0; i < 5; i++) begin
            imem_ack   = (i % 2) == 0;
            imem_rdata = 32'h1111_0000 + 32'(i);
            tick();
            chk("stall_valid", 32'(IF_valid), 32'h1);
            chk("stall_pc", IF_PC, 32'h0000_3004);
            chk("stall_ins", IF_ins, mem(32'h0000_3004));
            chk("stall_req", 32'(imem_req), 32'h0);
            chk("stall_cnt", fetch_count, 32'h1);
        end
        imem_ack = 1'b0;
        accept("st1");

        // Redirect while 3008 is pending: drain then fetch 3100
        tick();
        chk("pend_addr", imem_addr, 32'h0000_3008);
        redirect = 1'b1; redirect_pc = 32'h0000_3100;
        tick();
        redirect = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("drain_req", 32'(imem_req), 32'h1);
            chk("drain_addr", imem_addr, 32'h0000_3008);
            chk("drain_valid", 32'(IF_valid), 32'h0);
            if (i < 2) tick();
        end
        imem_ack = 1'b1; imem_rdata = mem(32'h0000_3008);
        tick();
        imem_ack = 1'b0;
        chk("drain_valid2", 32'(IF_valid), 32'h0);
        exp_addr = 32'h0000_3100;
        ack_now("r1");
        accept("r1");

        // Ack and redirect together: no DRAIN, 3200 requested immediately
        imem_ack = 1'b1; imem_rdata = mem(imem_addr);
        redirect = 1'b1; redirect_pc = 32'h0000_3200;
        tick();
        imem_ack = 1'b0; redirect = 1'b0;
        chk("ackred_valid", 32'(IF_valid), 32'h0);
        exp_addr = 32'h0000_3200;
        ack_now("r2");

        // Redirect in HAVE beats PCWrite; unaligned target is word-aligned
        check_have("r2");
        redirect = 1'b1; redirect_pc = 32'h0000_3302; PCWrite = 1'b1;
        tick();
        redirect = 1'b0; PCWrite = 1'b0;
        chk("hred_valid", 32'(IF_valid), 32'h0);
        chk("hred_cnt", fetch_count, exp_count);
        chk("hred_addr", imem_addr, 32'h0000_3300);

        // Redirect into DRAIN, then newer redirect together with the ack
        redirect = 1'b1; redirect_pc = 32'h0000_3400;
        tick();
        redirect_pc = 32'h0000_3500; imem_ack = 1'b1;
        tick();
        redirect = 1'b0; imem_ack = 1'b0;
        chk("newest_addr", imem_addr, 32'h0000_3500);
        chk("newest_valid", 32'(IF_valid), 32'h0);

        // Reset while in DRAIN
        redirect = 1'b1; redirect_pc = 32'h0000_3600;
        tick();
        redirect = 1'b0;
        rst = 1'b1; imem_ack = 1'b1;
        tick();
        rst = 1'b0; imem_ack = 1'b0;
        chk("drst_req", 32'(imem_req), 32'h1);
        chk("drst_addr", imem_addr, RESET_PC);
        chk("drst_cnt", fetch_count, 32'h0);
        chk("drst_valid", 32'(IF_valid), 32'h0);
        exp_addr = RESET_PC; exp_count = 32'h0; sb.delete();

        // PC wrap: fetch at FFFF_FFFC, next request at 0
        imem_ack = 1'b1; redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        imem_ack = 1'b0; redirect = 1'b0;
        exp_addr = 32'hFFFF_FFFC;
        ack_now("wrap");
        accept("wrap");
        chk("wrap_addr0", imem_addr, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
